// File: rtl/pipeline_ctrl_pkg.sv
// Shared state encodings for the pipeline hazard controller and its debug trace.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MC_BUSY  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/mc_latency_counter.sv
// Down-counter tracking the remaining EX cycles of a multi-cycle op.
// Supports load, decrement and freeze (neither asserted), and exposes a zero flag.
module mc_latency_counter #(
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
// Define HAZARD_PERF_CNT_EN to add the perf_stall_cycles/perf_bubbles/perf_flushes counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REGFILE_LEN = 6,
  parameter int MC_LATENCY  = 4,
  parameter int CNT_WIDTH   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REGFILE_LEN-1:0] id_rs1,
  input  logic [REGFILE_LEN-1:0] id_rs2,
  input  logic [REGFILE_LEN-1:0] ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_mc_op,
  input  logic                   ex_branch_taken,
  input  logic                   mem_access,
  input  logic                   mem_ready,
  output logic                   mem_req,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   id_ex_stall,
  output logic                   ex_mem_stall,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_flush,
  output logic                   mem_wb_flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_bubbles,
  output logic [31:0]            perf_flushes
`endif
);

  localparam bit MC_EN = (MC_LATENCY > 1);
  localparam logic [CNT_WIDTH-1:0] MC_LOAD = CNT_WIDTH'(MC_EN ? MC_LATENCY - 2 : 0);

  state_t               state;
  state_t               ret_state;
  logic [CNT_WIDTH-1:0] mc_cnt;
  logic                 cnt_zero;
  logic                 mem_stall;
  logic                 mc_stall;
  logic                 load_use;
  logic                 mc_start;
  logic                 mc_dec;
  logic                 branch_issue;
  logic                 bubble_issue;

  assign mem_stall = mem_access & ~mem_ready;
  assign load_use  = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign mc_start  = (state == ST_RUN) && !mem_stall && ex_mc_op && MC_EN;
  assign mc_dec    = (state == ST_MC_BUSY) && !mem_stall && !cnt_zero;

  mc_latency_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_mc_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (mc_start),
    .load_val (MC_LOAD),
    .dec      (mc_dec),
    .cnt      (mc_cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    mc_stall = 1'b0;
    case (state)
      ST_RUN:      mc_stall = ex_mc_op && MC_EN;
      ST_MC_BUSY:  mc_stall = !cnt_zero;
      ST_MEM_WAIT: mc_stall = (ret_state == ST_MC_BUSY) && !cnt_zero;
      default:     mc_stall = 1'b0;
    endcase
  end

  // A taken branch squashes ID, so a pending load-use in ID never reaches the outputs.
  assign branch_issue = !rst && !mem_stall && !mc_stall && ex_branch_taken;
  assign bubble_issue = !rst && !mem_stall && !mc_stall && !ex_branch_taken && load_use;

  always_comb begin
    mem_req      = !rst && mem_access;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (mc_stall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (branch_issue) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (bubble_issue) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  // ex_mc_op only matters in RUN, so an op held in EX cannot retrigger itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      ret_state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state     <= ST_MEM_WAIT;
            ret_state <= ST_RUN;
          end else if (ex_mc_op && MC_EN) begin
            state <= ST_MC_BUSY;
          end
        end
        ST_MC_BUSY: begin
          if (mem_stall) begin
            state     <= ST_MEM_WAIT;
            ret_state <= ST_MC_BUSY;
          end else if (cnt_zero) begin
            state <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) state <= ret_state;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_bubbles      <= '0;
      perf_flushes      <= '0;
    end else begin
      if (pc_stall)     perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (bubble_issue) perf_bubbles      <= perf_bubbles + 32'd1;
      if (branch_issue) perf_flushes      <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule
